// File: rtl/led_pattern_ctrl.sv
// LED bar sequencer: step-rate prescaler, pattern-mode FSM and bounce direction.
// Define LED_PATTERN_BLINK_EN to include the BLINK mode (else modes cycle 0->1->2).
module led_pattern_ctrl #(
  parameter int WIDTH = 10,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             mode_next,
  input  logic [DIV_W-1:0] step_div,
  output logic [WIDTH-1:0] leds,
  output logic [1:0]       mode,
  output logic             step
);

  typedef enum logic [1:0] {
    BOUNCE = 2'd0,
    CHASE  = 2'd1,
    FILL   = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  mode_t            cur_mode;
  logic             dir_up;
  logic [DIV_W-1:0] cnt;

  function automatic mode_t next_mode(input mode_t m);
`ifdef LED_PATTERN_BLINK_EN
    return mode_t'(m + 2'd1);
`else
    return (m == FILL) ? BOUNCE : mode_t'(m + 2'd1);
`endif
  endfunction

  function automatic logic [WIDTH-1:0] load_value(input mode_t m);
    return (m == BOUNCE) ? WIDTH'(3'b111) :
           (m == CHASE)  ? WIDTH'(1'b1)   : '0;
  endfunction

  assign mode = cur_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_mode <= BOUNCE;
      leds     <= WIDTH'(3'b111);
      dir_up   <= 1'b1;
      cnt      <= '0;
      step     <= 1'b0;
    end else begin
      step <= 1'b0;
      // A mode switch swallows any tick that lands on the same cycle.
      if (mode_next) begin
        cur_mode <= next_mode(cur_mode);
        leds     <= load_value(next_mode(cur_mode));
        dir_up   <= 1'b1;
        cnt      <= '0;
      end else if (run) begin
        if (cnt >= step_div) begin
          cnt  <= '0;
          step <= 1'b1;
          case (cur_mode)
            BOUNCE: begin
              // Direction flips on the same tick that reaches an end.
              if (dir_up && leds[WIDTH-1]) begin
                dir_up <= 1'b0;
                leds   <= leds >> 1;
              end else if (!dir_up && leds[0]) begin
                dir_up <= 1'b1;
                leds   <= {leds[WIDTH-2:0], 1'b0};
              end else if (dir_up) begin
                leds   <= {leds[WIDTH-2:0], 1'b0};
              end else begin
                leds   <= leds >> 1;
              end
            end
            CHASE: leds <= {leds[WIDTH-2:0], leds[WIDTH-1]};
            FILL:  leds <= (&leds) ? '0 : {leds[WIDTH-2:0], 1'b1};
`ifdef LED_PATTERN_BLINK_EN
            BLINK: leds <= ~leds;
`endif
            default: leds <= leds;
          endcase
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: a tick-index reference model predicts
// each cycle's outputs, and an independent monitor pops and compares them.
module tb_led_pattern_ctrl;
  localparam int W     = 10;
  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic             mode_next = 1'b0;
  logic [DIV_W-1:0] step_div = '0;
  logic [W-1:0]     leds;
  logic [1:0]       mode;
  logic             step;

  led_pattern_ctrl #(.WIDTH(W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .run(run), .mode_next(mode_next),
    .step_div(step_div), .leds(leds), .mode(mode), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] leds;
    logic [1:0]   mode;
    logic         step;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: mode, number of ticks since mode entry, prescaler count.
  int m_mode = 0;
  int m_k    = 0;
  int m_cnt  = 0;
  bit m_step = 0;

`ifdef LED_PATTERN_BLINK_EN
  localparam int NMODES = 4;
`else
  localparam int NMODES = 3;
`endif

  // LED image after k ticks in mode m, computed directly from the pattern shape.
  function automatic logic [W-1:0] pat(input int m, input int k);
    int per, p, sh, j;
    logic [W-1:0] ones;
    ones = '1;
    case (m)
      0: begin
        per = 2 * (W - 3);
        p   = k % per;
        sh  = (p <= W - 3) ? p : per - p;
        return W'(7) << sh;
      end
      1: return W'(1) << (k % W);
      2: begin
        j = k % (W + 1);
        return W'((1 << j) - 1);
      end
      default: return (k % 2 == 1) ? ones : '0;
    endcase
  endfunction

  task automatic drive(input logic r, input logic ru, input logic mn, input int d);
    exp_t e;
    @(negedge clk);
    rst = r; run = ru; mode_next = mn; step_div = DIV_W'(d);
    if (r) begin
      m_mode = 0; m_k = 0; m_cnt = 0; m_step = 0;
    end else begin
      m_step = 0;
      if (mn) begin
        m_mode = (m_mode + 1) % NMODES; m_k = 0; m_cnt = 0;
      end else if (ru) begin
        if (m_cnt >= d) begin
          m_cnt = 0; m_k++; m_step = 1;
        end else begin
          m_cnt++;
        end
      end
    end
    e.leds = pat(m_mode, m_k);
    e.mode = 2'(m_mode);
    e.step = m_step;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks += 3;
        if (leds !== e.leds) begin
          errors++; $display("FAIL leds t=%0t got %h exp %h", $time, leds, e.leds);
        end
        if (mode !== e.mode) begin
          errors++; $display("FAIL mode t=%0t got %0d exp %0d", $time, mode, e.mode);
        end
        if (step !== e.step) begin
          errors++; $display("FAIL step t=%0t got %b exp %b", $time, step, e.step);
        end
      end
    end
  end

  initial begin
    int d;
    // Reset, then bounce at full rate through more than one period.
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    repeat (20) drive(0, 1, 0, 0);
    // Divide by 4, with a frozen stretch mid-count.
    drive(1, 0, 0, 3);
    repeat (6) drive(0, 1, 0, 3);
    repeat (5) drive(0, 0, 0, 3);
    repeat (10) drive(0, 1, 0, 3);
    // CHASE full wrap, then FILL to all ones and clear.
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 0);
    repeat (12) drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    repeat (13) drive(0, 1, 0, 0);
    // Mode switch on exactly the cycle that would tick.
    drive(1, 0, 0, 3);
    repeat (3) drive(0, 1, 0, 3);
    drive(0, 1, 1, 3);
    repeat (6) drive(0, 1, 0, 3);
    // Reset during CHASE at 0x040.
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    repeat (6) drive(0, 1, 0, 0);
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 0);
    // Mode wrap, then blink ticks if present.
    repeat (NMODES) drive(0, 0, 1, 0);
    repeat (3) drive(0, 1, 0, 0);
    repeat (NMODES - 1) drive(0, 0, 1, 0);
    repeat (4) drive(0, 1, 0, 0);
    // Held mode_next advances once per cycle.
    repeat (5) drive(0, 1, 1, 0);
    // Randomized traffic, including step_div drops below the running count.
    d = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0)
        d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 5));
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 24) == 0, d);
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    if (q.size() != 0) begin
      errors++; $display("FAIL drain queue left %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Sequencer for the LED bar pattern generator. Owns the step-rate prescaler, the pattern-mode state machine and the bounce direction, and drives the LED bar directly. One step per prescaler tick while `run` is high; `mode_next` cycles through the pattern modes. Sits between the board clock and the LED pins, replacing free-running per-clock shifting with rate-controlled, mode-selectable sequencing.

## Interface
- `WIDTH`, 10: number of LEDs driven (min 4).
- `DIV_W`, 24: prescaler counter width.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `run` input 1: level; 1 = prescaler counts and pattern advances, 0 = freeze.
- `mode_next` input 1: single-cycle request to advance to the next mode.
- `step_div` input DIV_W: tick period minus one, in clocks.
- `leds` output WIDTH: LED drive, 1 = lit.
- `mode` output 2: current mode (0 BOUNCE, 1 CHASE, 2 FILL, 3 BLINK).
- `step` output 1: registered pulse, high for one cycle on each pattern advance.

## Operation
- Prescaler `cnt` (DIV_W bits):
  - when `run`=1: if `cnt >= step_div`, tick and `cnt`←0; else `cnt`←`cnt`+1.
  - `step_div` is compared live; lowering it below `cnt` forces a tick on the next counting cycle.
  - `step_div`=0 ticks every cycle while `run`=1.
  - `run`=0: `cnt` holds, no ticks.
- On tick, `leds` advances per mode and `step`=1 in the same registered update.
- BOUNCE (load value `0b111` in bits 2:0): block of three lit LEDs; direction reg `dir_up`.
  - `dir_up`=1 and `leds[WIDTH-1]`=1: `dir_up`←0 and shift toward LSB on this tick.
  - `dir_up`=0 and `leds[0]`=1: `dir_up`←1 and shift toward MSB on this tick.
  - Otherwise shift in `dir_up` direction, zero fill.
  - Period 2·(WIDTH−3) ticks.
- CHASE (load `1`): single lit LED rotates toward MSB; bit WIDTH-1 wraps to bit 0. Period WIDTH.
- FILL (load 0): `leds`←`{leds[WIDTH-2:0],1}` until all ones; the next tick clears to 0. Period WIDTH+1.
- BLINK (load 0): `leds`←`~leds` each tick. Period 2.
- `mode_next`=1:
  - `mode`←next mode (3→0 wrap).
  - `leds`←new mode's load value; `dir_up`←1; `cnt`←0; `step`=0.
  - Acts regardless of `run`.
- Simultaneous `mode_next` and tick: mode switch wins; the tick is discarded and `step` is not asserted.
- `leds` must only ever hold states defined by the current mode's sequence.

## Timing
- Reset values: `mode`=0, `leds`=`0b111` (bits 2:0), `dir_up`=1, `cnt`=0, `step`=0.
- `rst` dominates all other inputs, including mid-step and mid-mode-switch.
- Sequence after reset release with `run`=1 and `step_div`=N:
  - First tick on the (N+1)th rising edge.
  - Ticks every N+1 clocks thereafter.
- `leds`, `mode` and `step` are all registered and update together on the tick edge; no combinational input-to-output paths.
- `mode_next` latency: new `mode` and load pattern visible 1 clock after the edge that samples it. The next tick follows N+1 counting clocks later.
- `mode_next` held high for K cycles advances the mode K times. It is not edge-detected; the upstream debouncer supplies pulses.

## Configuration
- `LED_PATTERN_BLINK_EN`:
  - Defined: BLINK mode present; mode sequence 0→1→2→3→0.
  - Undefined: BLINK logic removed; mode sequence 0→1→2→0; `mode` never equals 3.

## Test plan
- Reset, `run`=1, `step_div`=0, WIDTH=10 → `leds` 0x007, 0x00E, …, 0x380 (tick 7), 0x1C0 (tick 8), …, 0x007 (tick 14), 0x00E (tick 15); `step` high every cycle.
- `step_div`=3, `run`=1 → `step` pulses every 4 clocks. Drop `run` for 5 cycles mid-count → no pulses, `cnt` frozen; resumes with the remaining count.
- `mode_next` pulse → `mode`=1, `leds`=0x001. Ticks → 0x002 … 0x200 → 0x001. Second pulse → `mode`=2, `leds`=0; 10 ticks → 0x3FF; 11th tick → 0x000.
- `mode_next` asserted on the exact cycle `cnt`==`step_div` → mode advances, `leds` = load value, `step`=0, `cnt`=0.
- `rst` asserted during CHASE at `leds`=0x040 → next edge `mode`=0, `leds`=0x007, `step`=0.
- Mode wrap:
  - With `LED_PATTERN_BLINK_EN`: 4 pulses return to `mode`=0; in BLINK, ticks alternate 0x3FF/0x000.
  - Without the macro: 3 pulses return to `mode`=0.
